// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  // LEGv8 NOP encoding, for consumers that need a filler instruction.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; the low two bits of a target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries with synchronous flush.
// Latency: a pushed entry becomes visible at the head on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty, flush wins over both.
// Ports: clk/rst_n, push/push_dat, pop, flush, count, empty/full, head_dat.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output fetch_entry_t     head_dat
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[head_q];

  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch sequencer: drives imem address from fetch_pc and queues {pc, instr} for decode.
// Latency: a fetched word reaches deq one cycle after its enqueue; redirect refills after one cycle.
// Backpressure: valid/ready to decode; fetch stalls (pc held) while the queue is full.
// Ports: clk/reset (async active-low), fetch_en, imem_addr/imem_q, redirect_valid/redirect_pc,
//        deq_valid/deq_ready/deq_instr/deq_pc, q_count, fetch_cnt/flush_cnt.
// Optional: define FETCH_STATS_EN for saturating enqueue/flush counters (tied to 0 otherwise).
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int          AW       = 6,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [AW-1:0]            imem_addr,
  input  logic [31:0]              imem_q,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [63:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              flush_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            enq, deq_fire;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    enq_dat, head;

  assign imem_addr = fetch_pc_q[AW+1:2];
  assign enq_dat   = '{pc: fetch_pc_q, instr: imem_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (enq),
    .push_dat (enq_dat),
    .pop      (deq_fire),
    .flush    (redirect_valid),
    .count    (q_count),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .head_dat (head)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state logic; redirect overrides every state.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = fetch_en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: if (fetch_en) state_d = RUN;
        RUN: begin
          if (!fetch_en)
            state_d = IDLE;
          else if (enq && !deq_fire && q_count == CNT_W'(DEPTH - 1))
            state_d = FULL;
        end
        FULL: begin
          if (!fetch_en)     state_d = IDLE;
          else if (deq_fire) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and datapath control. FULL never enqueues, so a pop there frees a slot
  // that is only refilled after the return to RUN.
  always_comb begin
    deq_valid  = !fifo_empty && !redirect_valid;
    deq_fire   = deq_valid && deq_ready;
    enq        = (state_q == RUN) && fetch_en && !fifo_full && !redirect_valid;
    deq_instr  = deq_valid ? head.instr : '0;
    deq_pc     = deq_valid ? head.pc : '0;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = align_pc(redirect_pc);
    else if (enq)       fetch_pc_d = fetch_pc_q + 64'd4;
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [32:0] flush_sum;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_sum   = {1'b0, flush_cnt_q} + 33'(q_count);
    if (enq && fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + 32'd1;
    // Occupancy at the redirect cycle is exactly what gets discarded.
    if (redirect_valid) flush_cnt_d = flush_sum[32] ? '1 : flush_sum[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
